// File: rtl/alt_pkg.sv
// Shared definitions for the ALT frame sequencer slice.
//   - 2-bit FSM state encodings and the matching enum
//   - default raster geometry and drain length
//   - counter widths and RGB565 field offsets
package alt_pkg;

  localparam int H_ACTIVE_DEF     = 640;
  localparam int V_ACTIVE_DEF     = 480;
  localparam int DRAIN_CYCLES_DEF = 6;

  localparam int CNT_W   = 10;  // raster counters; geometry must fit in 1024
  localparam int DRAIN_W = 4;   // drain counter; DRAIN_CYCLES must be 1..15
  localparam int RGB_W   = 16;

  // RGB565 layout {R5,G6,B5}
  localparam int R_LSB = 11;
  localparam int R_W   = 5;
  localparam int G_LSB = 5;
  localparam int G_W   = 6;
  localparam int B_LSB = 0;
  localparam int B_W   = 5;

  localparam logic [1:0] ST_IDLE_ENC     = 2'd0;
  localparam logic [1:0] ST_WAIT_SOF_ENC = 2'd1;
  localparam logic [1:0] ST_RUN_ENC      = 2'd2;
  localparam logic [1:0] ST_DRAIN_ENC    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = ST_IDLE_ENC,
    ST_WAIT_SOF = ST_WAIT_SOF_ENC,
    ST_RUN      = ST_RUN_ENC,
    ST_DRAIN    = ST_DRAIN_ENC
  } state_e;

endpackage

// File: rtl/alt_raster_counter.sv
// X/Y raster position counter for the paired pixel stream.
//   clk_pixl, reset : pixel clock, asynchronous active-low reset
//   clr             : return to (0,0); wins over inc
//   inc             : advance one pixel, wrapping X at the line end and Y at the frame end
//   x, y            : current column / row
//   eol             : x is the last column
//   eof             : x,y is the last pixel of the frame
module alt_raster_counter
  import alt_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic             clk_pixl,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             eol,
  output logic             eof
);

  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(V_ACTIVE - 1);

  assign eol = (x == X_LAST);
  assign eof = eol && (y == Y_LAST);

  // NOTE: clocked state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_pixl or negedge reset) begin
    if (!reset) begin
      x <= '0;
      y <= '0;
    end else if (clr) begin
      x <= '0;
      y <= '0;
    end else if (inc) begin
      if (eol) begin
        x <= '0;
        y <= eof ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alt_frame_sequencer.sv
// Frame-level controller ahead of the ALT statistics datapath.
// Pairs DVI and CCD RGB565 pixels one-for-one, supplies raster coordinates,
// and brackets each frame with SOF alignment, a pipeline drain and a
// results-valid pulse.
//   clk_pixl, reset          : pixel clock, asynchronous active-low reset
//   enable_i                 : 1 = run frames, 0 = abort to IDLE
//   sof_i                    : start-of-frame pulse common to both streams
//   dvi_valid_i/rgb_i/ready_o: DVI stream handshake
//   ccd_valid_i/rgb_i/ready_o: CCD stream handshake
//   alt_valid_o, alt_syncX_o, alt_syncY_o, alt_dvi_rgb_o, alt_ccd_rgb_o
//                            : registered paired pixel to the datapath
//   stats_valid_o            : 1-cycle pulse, frame results valid
//   busy_o                   : in RUN or DRAIN
//   frame_cnt_o              : completed frames, wrapping
//   sync_err_o               : sticky, SOF seen mid-frame
module alt_frame_sequencer
  import alt_pkg::*;
#(
  parameter int H_ACTIVE     = H_ACTIVE_DEF,
  parameter int V_ACTIVE     = V_ACTIVE_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic             clk_pixl,
  input  logic             reset,
  input  logic             enable_i,
  input  logic             sof_i,
  input  logic             dvi_valid_i,
  input  logic [RGB_W-1:0] dvi_rgb_i,
  output logic             dvi_ready_o,
  input  logic             ccd_valid_i,
  input  logic [RGB_W-1:0] ccd_rgb_i,
  output logic             ccd_ready_o,
  output logic             alt_valid_o,
  output logic [CNT_W-1:0] alt_syncX_o,
  output logic [CNT_W-1:0] alt_syncY_o,
  output logic [RGB_W-1:0] alt_dvi_rgb_o,
  output logic [RGB_W-1:0] alt_ccd_rgb_o,
  output logic             stats_valid_o,
  output logic             busy_o,
  output logic [15:0]      frame_cnt_o,
  output logic             sync_err_o
);

  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
  // Cycle before the last drain cycle; only meaningful when DRAIN_CYCLES >= 2.
  localparam logic [DRAIN_W-1:0] DRAIN_PRE  = DRAIN_W'(DRAIN_CYCLES - 2);

  state_e             state, next_state;
  logic [CNT_W-1:0]   x, y;
  logic               eol, eof;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               pair_ok, accept, last_accept, drain_last;
  logic               raster_clr, stats_next;

  // Both streams hand over together; a lone valid stream is never consumed.
  assign pair_ok     = (state == ST_RUN) && dvi_valid_i && ccd_valid_i;
  assign dvi_ready_o = pair_ok;
  assign ccd_ready_o = pair_ok;

  // A mid-frame SOF wins: the handshake completes but the pixel is dropped.
  assign accept      = pair_ok && !sof_i;
  assign last_accept = accept && eol && eof;
  assign drain_last  = (state == ST_DRAIN) && (drain_cnt == DRAIN_LAST);

  alt_raster_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_raster (
    .clk_pixl (clk_pixl),
    .reset    (reset),
    .clr      (raster_clr),
    .inc      (accept),
    .x        (x),
    .y        (y),
    .eol      (eol),
    .eof      (eof)
  );

  // NOTE: every signal written here gets a default first so no path through
  // the block can leave it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    raster_clr = 1'b0;
    stats_next = 1'b0;
    if (!enable_i) begin
      next_state = ST_IDLE;
      raster_clr = 1'b1;
    end else begin
      case (state)
        ST_IDLE:     next_state = ST_WAIT_SOF;
        ST_WAIT_SOF: begin
          if (sof_i) begin
            next_state = ST_RUN;
            raster_clr = 1'b1;
          end
        end
        ST_RUN: begin
          if (sof_i) begin
            raster_clr = 1'b1;
          end else if (last_accept) begin
            next_state = ST_DRAIN;
            // With a single drain cycle the pulse lands right after the last accept.
            stats_next = (DRAIN_CYCLES == 1);
          end
        end
        ST_DRAIN: begin
          if (drain_last) begin
            next_state = ST_WAIT_SOF;
          end else if (drain_cnt == DRAIN_PRE) begin
            stats_next = 1'b1;
          end
        end
        default:     next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_pixl or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Held at zero outside DRAIN, so it reads 0 in the first drain cycle.
  always_ff @(posedge clk_pixl or negedge reset) begin
    if (!reset) begin
      drain_cnt <= '0;
    end else if (state != ST_DRAIN) begin
      drain_cnt <= '0;
    end else begin
      drain_cnt <= drain_cnt + 1'b1;
    end
  end

  // Status outputs are registered from the next-state decode so they line up
  // with the state they describe without a combinational path to the ports.
  always_ff @(posedge clk_pixl or negedge reset) begin
    if (!reset) begin
      busy_o        <= 1'b0;
      stats_valid_o <= 1'b0;
      frame_cnt_o   <= '0;
      sync_err_o    <= 1'b0;
      alt_valid_o   <= 1'b0;
      alt_syncX_o   <= '0;
      alt_syncY_o   <= '0;
      alt_dvi_rgb_o <= '0;
      alt_ccd_rgb_o <= '0;
    end else begin
      busy_o        <= (next_state == ST_RUN) || (next_state == ST_DRAIN);
      stats_valid_o <= stats_next;
      if (stats_next) begin
        frame_cnt_o <= frame_cnt_o + 1'b1;
      end
      // Sticky until the block is disabled; disable also clears it.
      sync_err_o  <= enable_i && (sync_err_o || ((state == ST_RUN) && sof_i));
      alt_valid_o <= accept;
      if (accept) begin
        alt_syncX_o   <= x;
        alt_syncY_o   <= y;
        alt_dvi_rgb_o <= dvi_rgb_i;
        alt_ccd_rgb_o <= ccd_rgb_i;
      end
    end
  end

endmodule

// File: tb/tb_alt_frame_sequencer.sv
// Self-checking bench for alt_frame_sequencer.
// Instance A uses a reduced 128x8 raster with a 6-cycle drain; instance B the
// 4x2 raster with a 1-cycle drain. Both share one set of inputs.
module tb_alt_frame_sequencer;
  import alt_pkg::*;

  localparam int HA = 128;
  localparam int VA = 8;
  localparam int DA = 6;
  localparam int HB = 4;
  localparam int VB = 2;
  localparam int DB = 1;

  logic        clk_pixl = 1'b0;
  logic        reset = 1'b0;
  logic        enable_i = 1'b0;
  logic        sof_i = 1'b0;
  logic        dvi_valid_i = 1'b0;
  logic        ccd_valid_i = 1'b0;
  logic [15:0] dvi_rgb_i = '0;
  logic [15:0] ccd_rgb_i = '0;

  logic        a_dvi_ready, a_ccd_ready, a_alt_valid, a_stats, a_busy, a_sync_err;
  logic [9:0]  a_x, a_y;
  logic [15:0] a_dvi, a_ccd, a_frame_cnt;
  logic        b_dvi_ready, b_ccd_ready, b_alt_valid, b_stats, b_busy, b_sync_err;
  logic [9:0]  b_x, b_y;
  logic [15:0] b_dvi, b_ccd, b_frame_cnt;

  always #5 clk_pixl = ~clk_pixl;

  alt_frame_sequencer #(.H_ACTIVE(HA), .V_ACTIVE(VA), .DRAIN_CYCLES(DA)) dut_a (
    .clk_pixl(clk_pixl), .reset(reset), .enable_i(enable_i), .sof_i(sof_i),
    .dvi_valid_i(dvi_valid_i), .dvi_rgb_i(dvi_rgb_i), .dvi_ready_o(a_dvi_ready),
    .ccd_valid_i(ccd_valid_i), .ccd_rgb_i(ccd_rgb_i), .ccd_ready_o(a_ccd_ready),
    .alt_valid_o(a_alt_valid), .alt_syncX_o(a_x), .alt_syncY_o(a_y),
    .alt_dvi_rgb_o(a_dvi), .alt_ccd_rgb_o(a_ccd), .stats_valid_o(a_stats),
    .busy_o(a_busy), .frame_cnt_o(a_frame_cnt), .sync_err_o(a_sync_err)
  );

  alt_frame_sequencer #(.H_ACTIVE(HB), .V_ACTIVE(VB), .DRAIN_CYCLES(DB)) dut_b (
    .clk_pixl(clk_pixl), .reset(reset), .enable_i(enable_i), .sof_i(sof_i),
    .dvi_valid_i(dvi_valid_i), .dvi_rgb_i(dvi_rgb_i), .dvi_ready_o(b_dvi_ready),
    .ccd_valid_i(ccd_valid_i), .ccd_rgb_i(ccd_rgb_i), .ccd_ready_o(b_ccd_ready),
    .alt_valid_o(b_alt_valid), .alt_syncX_o(b_x), .alt_syncY_o(b_y),
    .alt_dvi_rgb_o(b_dvi), .alt_ccd_rgb_o(b_ccd), .stats_valid_o(b_stats),
    .busy_o(b_busy), .frame_cnt_o(b_frame_cnt), .sync_err_o(b_sync_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [15:0] dvi;
    logic [15:0] ccd;
  } pix_t;

  pix_t       sb[$];
  int         a_pulses = 0;
  logic [19:0] a_last_xy = '0;
  bit         b_mon = 1'b0;
  logic [9:0] b_xs[$];

  // Scoreboard side: every alt pulse of instance A must match the oldest expected pixel.
  always @(negedge clk_pixl) begin
    pix_t p;
    if (a_alt_valid) begin
      a_pulses++;
      a_last_xy = {a_x, a_y};
      if (sb.size() == 0) begin
        check("alt_unexpected_pulse", 64'(a_alt_valid), 64'd0);
      end else begin
        p = sb.pop_front();
        check("alt_pixel", 64'({a_x, a_y, a_dvi, a_ccd}), 64'(p));
      end
    end
    if (b_mon && b_alt_valid) b_xs.push_back(b_x);
  end

  // Reference model of instance A's pairing and raster counting.
  bit m_run = 1'b0;
  int mx = 0;
  int my = 0;

  task automatic tick();
    @(posedge clk_pixl);
    #1;
  endtask

  task automatic cycle(input logic en, input logic sf, input logic dv, input logic cv,
                       input logic [15:0] dr, input logic [15:0] cr);
    logic rdy_exp, acc;
    pix_t p;
    enable_i = en; sof_i = sf; dvi_valid_i = dv; ccd_valid_i = cv;
    dvi_rgb_i = dr; ccd_rgb_i = cr;
    #1;
    rdy_exp = m_run && dv && cv;
    check("ready_pair", 64'({a_dvi_ready, a_ccd_ready}), 64'({rdy_exp, rdy_exp}));
    acc = rdy_exp && !sf;
    if (acc) begin
      p.x = 10'(mx); p.y = 10'(my); p.dvi = dr; p.ccd = cr;
      sb.push_back(p);
      if (mx == HA - 1) begin
        mx = 0;
        if (my == VA - 1) begin my = 0; m_run = 1'b0; end
        else my++;
      end else begin
        mx++;
      end
    end
    if (sf && en) begin m_run = 1'b1; mx = 0; my = 0; end
    if (!en) m_run = 1'b0;
    tick();
  endtask

  task automatic wait_stats(input bit use_b, input int limit, output int n);
    n = 1;
    while (((use_b ? b_stats : a_stats) == 1'b0) && n < limit) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      n++;
    end
    if ((use_b ? b_stats : a_stats) == 1'b0) n = -1;
  endtask

  typedef struct {
    logic dv;
    logic cv;
    logic [15:0] dr;
    logic [15:0] cr;
    logic acc;
  } vec_t;

  vec_t vt[10];
  logic [9:0] exp_bx[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, n, guard;
    logic [15:0] last_d;
    bit seen;

    // Stall pattern: two pairs, CCD absent 5 cycles with DVI held, pair, lone CCD, none.
    vt[0] = '{1'b1, 1'b1, 16'h1111, 16'h2222, 1'b1};
    vt[1] = '{1'b1, 1'b1, 16'h3333, 16'h4444, 1'b1};
    for (int i = 2; i < 7; i++) vt[i] = '{1'b1, 1'b0, 16'hABCD, 16'h0000, 1'b0};
    vt[7] = '{1'b1, 1'b1, 16'hABCD, 16'h5A5A, 1'b1};
    vt[8] = '{1'b0, 1'b1, 16'h0000, 16'h6666, 1'b0};
    vt[9] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
    exp_bx = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd0, 10'd1, 10'd2, 10'd3};

    // Reset state
    #12;
    check("rst_flags", 64'({a_alt_valid, a_busy, a_stats, a_sync_err, a_dvi_ready, a_ccd_ready}), 64'd0);
    check("rst_xy", 64'({a_x, a_y}), 64'd0);
    check("rst_rgb", 64'({a_dvi, a_ccd}), 64'd0);
    check("rst_frame_cnt", 64'(a_frame_cnt), 64'd0);
    tick();
    reset = 1'b1;

    // IDLE -> WAIT_SOF -> RUN; the SOF cycle accepts nothing
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    check("wait_sof_not_busy", 64'(a_busy), 64'd0);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 16'h0BAD, 16'h0BAD);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 16'h0BAD, 16'h0BAD);
    check("run_busy", 64'(a_busy), 64'd1);
    check("sof_no_pixel", 64'(a_alt_valid), 64'd0);

    // CCD stall with DVI held: no readiness, X frozen, DVI data paired later
    last_d = 16'h0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, vt[i].dv, vt[i].cv, vt[i].dr, vt[i].cr);
      check("stall_alt_valid", 64'(a_alt_valid), 64'(vt[i].acc));
      if (vt[i].acc) last_d = vt[i].dr;
      else check("stall_hold_dvi", 64'(a_dvi), 64'(last_d));
    end

    // SOF mid-frame at (10,3)
    guard = 0;
    while (!(mx == 10 && my == 3) && guard < 5000) begin
      cycle(1'b1, 1'b0, 1'b1, 1'b1, 16'($urandom), 16'($urandom));
      guard++;
    end
    check("reached_10_3", 64'({10'(mx), 10'(my)}), 64'({10'd10, 10'd3}));
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 16'hDEAD, 16'hBEEF);
    check("sof_mid_err", 64'(a_sync_err), 64'd1);
    check("sof_mid_dropped", 64'(a_alt_valid), 64'd0);
    p0 = a_pulses;

    // Full frame from (0,0), both streams valid every cycle
    guard = 0;
    while (m_run && guard < 5000) begin
      cycle(1'b1, 1'b0, 1'b1, 1'b1, 16'($urandom), 16'($urandom));
      guard++;
    end
    check("drain_busy", 64'(a_busy), 64'd1);
    wait_stats(1'b0, 20, n);
    check("stats_latency_a", 64'(n), 64'(DA));
    check("frame_cnt_1", 64'(a_frame_cnt), 64'd1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    check("stats_one_cycle", 64'(a_stats), 64'd0);
    check("frame_pulses", 64'(a_pulses - p0), 64'(HA * VA));
    check("last_pixel_xy", 64'(a_last_xy), 64'({10'(HA - 1), 10'(VA - 1)}));
    check("sync_err_sticky", 64'(a_sync_err), 64'd1);

    // Second frame, enable dropped in the third drain cycle
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    guard = 0;
    while (m_run && guard < 5000) begin
      cycle(1'b1, 1'b0, 1'b1, 1'b1, 16'($urandom), 16'($urandom));
      guard++;
    end
    check("sync_err_frame2", 64'(a_sync_err), 64'd1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    check("drain3_busy", 64'(a_busy), 64'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    check("abort_idle", 64'(a_busy), 64'd0);
    seen = a_stats;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      seen = seen | a_stats;
    end
    check("abort_no_stats", 64'(seen), 64'd0);
    check("abort_frame_cnt", 64'(a_frame_cnt), 64'd1);
    check("abort_err_clear", 64'(a_sync_err), 64'd0);

    // Reset in RUN at X=100
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < 100; i++) cycle(1'b1, 1'b0, 1'b1, 1'b1, 16'(i + 1), 16'(~i));
    check("pre_reset_x", 64'(mx), 64'd100);
    reset = 1'b0;
    #1;
    check("mid_rst_flags", 64'({a_alt_valid, a_busy, a_stats, a_sync_err, a_dvi_ready, a_ccd_ready}), 64'd0);
    check("mid_rst_xy", 64'({a_x, a_y}), 64'd0);
    check("mid_rst_rgb", 64'({a_dvi, a_ccd}), 64'd0);
    check("mid_rst_frame_cnt", 64'(a_frame_cnt), 64'd0);
    sb.delete();
    m_run = 1'b0; mx = 0; my = 0;
    tick();
    reset = 1'b1;
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 16'h0, 16'h0);
    check("idle_sof_ignored", 64'({a_busy, a_sync_err}), 64'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    check("idle_to_wait", 64'(a_busy), 64'd0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    check("wait_to_run", 64'(a_busy), 64'd1);

    // Small geometry: 4x2 raster, 1-cycle drain
    reset = 1'b0;
    #1;
    sb.delete();
    m_run = 1'b0; mx = 0; my = 0;
    tick();
    reset = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    b_mon = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 1'b1, 16'(16'h100 + i), 16'(16'h200 + i));
      if (i == 6) check("b_no_early_stats", 64'(b_stats), 64'd0);
    end
    wait_stats(1'b1, 10, n);
    check("stats_latency_b", 64'(n), 64'(DB));
    check("b_frame_cnt", 64'(b_frame_cnt), 64'd1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    b_mon = 1'b0;
    check("b_pulse_count", 64'(b_xs.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < b_xs.size()) check("b_x_seq", 64'(b_xs[i]), 64'(exp_bx[i]));
    end

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
